// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encodings for the buffered UART
package uart_pkg;

    localparam int DATA_W = 8;

    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with combinational head; push while full is
// accepted only when a pop frees the slot in the same cycle
module uart_fifo
    import uart_pkg::*;
#(
    parameter int AW = 4,
    parameter int W  = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_buffered.sv
// rtl/uart_buffered.sv - 8N1 UART on the CPU I/O bus with TX/RX FIFOs;
// optional registered interrupt output when UART_IRQ_EN is defined
module uart_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] io_bus,
    input  logic              sel_data,
    input  logic              sel_status,
    input  logic              rnw,
    output logic              serial_tx,
    input  logic              serial_rx
`ifdef UART_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);

    logic data_wr, data_rd, status_rd;
    assign data_wr   = sel_data & ~rnw;
    assign data_rd   = sel_data & rnw;
    assign status_rd = sel_status & rnw;

    logic [DATA_W-1:0] tx_rdata, rx_rdata, rx_shift, tx_shift;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [FIFO_AW:0]  tx_count, rx_count;
    logic              tx_pop, rx_push;
    logic              unused_fifo_count;
    assign unused_fifo_count = &{1'b0, tx_count, rx_count};

    uart_fifo #(.AW(FIFO_AW), .W(DATA_W)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .wdata(io_bus),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.AW(FIFO_AW), .W(DATA_W)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(data_rd), .wdata(rx_shift),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_state_t tx_state, tx_next;
    logic [DW-1:0] tx_div;
    logic [2:0]    tx_bit;
    logic          tx_div_end;
    assign tx_div_end = (tx_div == DIV_LAST);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE:  if (!tx_empty) begin tx_next = START; tx_pop = 1'b1; end
            START: if (tx_div_end) tx_next = DATA;
            DATA:  if (tx_div_end && tx_bit == 3'd7) tx_next = STOP;
            STOP: begin
                if (tx_div_end) begin
                    if (!tx_empty) begin tx_next = START; tx_pop = 1'b1; end
                    else           tx_next = IDLE;
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_div <= (tx_next != tx_state || tx_div_end) ? '0 : tx_div + 1'b1;
            if (tx_pop)                          tx_shift <= tx_rdata;
            else if (tx_state == DATA && tx_div_end) tx_shift <= tx_shift >> 1;
            if (tx_state != DATA) tx_bit <= '0;
            else if (tx_div_end)  tx_bit <= tx_bit + 1'b1;
        end
    end

    // Decoded from state so reset forces the line high without waiting for a clock
    always_comb begin
        serial_tx = 1'b1;
        case (tx_state)
            START:   serial_tx = 1'b0;
            DATA:    serial_tx = tx_shift[0];
            default: serial_tx = 1'b1;
        endcase
    end

    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= serial_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    uart_state_t rx_state, rx_next;
    logic [DW-1:0] rx_div;
    logic [2:0]    rx_bit;
    logic          rx_div_end, frame_set;
    assign rx_div_end = (rx_div == DIV_LAST);

    always_comb begin
        rx_next   = rx_state;
        rx_push   = 1'b0;
        frame_set = 1'b0;
        case (rx_state)
            IDLE:  if (rx_prev && !rx_s2) rx_next = START;
            START: if (rx_div == DIV_HALF) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_div_end && rx_bit == 3'd7) rx_next = STOP;
            STOP: begin
                if (rx_div_end) begin
                    rx_next   = IDLE;
                    rx_push   = rx_s2;
                    frame_set = ~rx_s2;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_div <= (rx_next != rx_state || (rx_state == DATA && rx_div_end)) ? '0 : rx_div + 1'b1;
            if (rx_state == DATA && rx_div_end) rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            if (rx_state != DATA) rx_bit <= '0;
            else if (rx_div_end)  rx_bit <= rx_bit + 1'b1;
        end
    end

    logic overrun, frame_err, overrun_set, tx_idle;
    // A CPU pop on the same edge frees the slot, so only an unread full FIFO overruns
    assign overrun_set = rx_push & rx_full & ~data_rd;
    assign tx_idle     = tx_empty & (tx_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set | (overrun & ~status_rd);
            frame_err <= frame_set | (frame_err & ~status_rd);
        end
    end

    logic [DATA_W-1:0] status, rd_val;
    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~rx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME_ERR] = frame_err;
    end

    assign rd_val = sel_data ? (rx_empty ? '0 : rx_rdata) : status;
    assign io_bus = ((sel_data | sel_status) & rnw) ? rd_val : {DATA_W{1'bz}};

`ifdef UART_IRQ_EN
    logic tx_idle_q, idle_pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_idle_q <= 1'b1;
            idle_pend <= 1'b0;
            irq       <= 1'b0;
        end else begin
            tx_idle_q <= tx_idle;
            idle_pend <= (tx_idle & ~tx_idle_q) | (idle_pend & ~status_rd);
            irq       <= ~rx_empty | overrun | frame_err | idle_pend;
        end
    end
`endif

endmodule
